// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl -- multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I datapath.
// Owns state sequencing, the shared memory handshake, the request timeout,
// the sticky trap flag and the retired-instruction counter. Per-instruction
// ALU/extension decode lives in the separate combinational decoder.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   Op, Funct3, Zero    opcode/funct3 from IR, ALU branch-taken flag
//   mem_ready           memory completes the current request this cycle
//   MemReq, MemWrite    memory request valid / request is a write
//   AddrSel             memory address: 0 = PC, 1 = ALU result
//   IRWrite, PCWrite    IR latch enable / PC update enable
//   NPCOp               000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR
//   RegWrite, WDSel     regfile write enable / write data 00 ALU 01 MEM 10 PC+4
//   state               current state encoding
//   instr_done          one-cycle retire pulse
//   instr_cnt           retired-instruction count (wraps)
//   trap                sticky illegal-opcode / bus-timeout flag
module mc_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AddrSel,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [2:0]       NPCOp,
  output logic             RegWrite,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             trap
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_TRAP = 3'd7;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       mem_req, mem_write, addr_sel, ir_write, pc_write, reg_write, done;
  logic [2:0] npc_op;
  logic [1:0] wd_sel;
  logic       is_load, is_store, is_branch, is_jal, is_jalr, legal, timeout;

  // Funct3 is intentionally unread: the branch condition arrives resolved on Zero.
  logic unused_funct3;
  assign unused_funct3 = ^Funct3;

  assign is_load   = (Op == OP_LOAD);
  assign is_store  = (Op == OP_STORE);
  assign is_branch = (Op == OP_BRANCH);
  assign is_jal    = (Op == OP_JAL);
  assign is_jalr   = (Op == OP_JALR);
  assign legal     = (Op == OP_RTYPE) || (Op == OP_ITYPE) || is_load || is_store ||
                     is_branch || is_jal || is_jalr || (Op == OP_LUI) || (Op == OP_AUIPC);
  // Ready in the limit cycle still completes, so timeout needs !mem_ready.
  assign timeout   = (wait_q >= TIMEOUT_LIM) && !mem_ready;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    npc_op    = 3'b000;
    reg_write = 1'b0;
    wd_sel    = 2'b00;
    done      = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_ID: state_d = legal ? S_EX : S_TRAP;
      S_EX: begin
        if (is_branch) begin
          pc_write = 1'b1;
          npc_op   = Zero ? 3'b001 : 3'b000;
          done     = 1'b1;
          state_d  = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            done     = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        done      = 1'b1;
        wd_sel    = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
        npc_op    = is_jal ? 3'b010 : (is_jalr ? 3'b100 : 3'b000);
        state_d   = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    wait_d = wait_q;
    if ((state_d != state_q) && ((state_d == S_IF) || (state_d == S_MEM)))
      wait_d = '0;
    else if (mem_req && !mem_ready)
      wait_d = wait_q + 8'd1;

    cnt_d = cnt_q + CNT_W'(done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is held at zero while reset is asserted.
  assign MemReq     = mem_req   & ~rst;
  assign MemWrite   = mem_write & ~rst;
  assign AddrSel    = addr_sel  & ~rst;
  assign IRWrite    = ir_write  & ~rst;
  assign PCWrite    = pc_write  & ~rst;
  assign NPCOp      = rst ? '0 : npc_op;
  assign RegWrite   = reg_write & ~rst;
  assign WDSel      = rst ? '0 : wd_sel;
  assign state      = rst ? '0 : state_q;
  assign instr_done = done & ~rst;
  assign instr_cnt  = rst ? '0 : cnt_q;
  assign trap       = (state_q == S_TRAP) & ~rst;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed testbench for mc_seq_ctrl (MEM_TIMEOUT overridden to 4).
module tb_mc_seq_ctrl;

  localparam int unsigned MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Zero;
  logic        mem_ready;
  logic        MemReq, MemWrite, AddrSel, IRWrite, PCWrite, RegWrite, instr_done, trap;
  logic [2:0]  NPCOp, state;
  logic [1:0]  WDSel;
  logic [31:0] instr_cnt;
  logic [12:0] ctl;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  mc_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Zero(Zero), .mem_ready(mem_ready),
    .MemReq(MemReq), .MemWrite(MemWrite), .AddrSel(AddrSel), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite), .WDSel(WDSel),
    .state(state), .instr_done(instr_done), .instr_cnt(instr_cnt), .trap(trap)
  );

  always #5 clk = ~clk;

  assign ctl = {MemReq, MemWrite, AddrSel, IRWrite, PCWrite, NPCOp, RegWrite, WDSel, instr_done, trap};

  function automatic logic [12:0] mk(input bit mr, input bit mw, input bit as, input bit ir,
                                     input bit pw, input bit [2:0] npc, input bit rw,
                                     input bit [1:0] wd, input bit dn, input bit tr);
    return {mr, mw, as, ir, pw, npc, rw, wd, dn, tr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  // Check state and control vector mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] c);
    #1;
    chk({tag, " state"}, {29'd0, state}, {29'd0, st});
    chk({tag, " ctl"}, {19'd0, ctl}, {19'd0, c});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] C0, C_IFR, C_IFW, C_MLD, C_MSTW, C_MSTD, C_TRAP;
    C0     = '0;
    C_IFR  = mk(1, 0, 0, 1, 0, 3'b000, 0, 2'b00, 0, 0);
    C_IFW  = mk(1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    C_MLD  = mk(1, 0, 1, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    C_MSTW = mk(1, 1, 1, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    C_MSTD = mk(1, 1, 1, 0, 1, 3'b000, 0, 2'b00, 1, 0);
    C_TRAP = mk(0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1);

    rst = 1'b1; Op = 7'b0110011; Funct3 = 3'b000; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", 3'd0, C0);

    // add, zero-wait memory
    rst = 1'b0; mem_ready = 1'b1;
    chk("cnt after reset", instr_cnt, 32'd0);
    cyc("add IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("add ID", 3'd1, C0);
    cyc("add EX", 3'd2, C0);
    cyc("add WB", 3'd4, mk(0, 0, 0, 0, 1, 3'b000, 1, 2'b00, 1, 0));
    chk("add cnt", instr_cnt, 32'd1);

    // lw with three data wait cycles
    Op = 7'b0000011; mem_ready = 1'b1;
    cyc("lw IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("lw ID", 3'd1, C0);
    cyc("lw EX", 3'd2, C0);
    cyc("lw MEM w0", 3'd3, C_MLD);
    cyc("lw MEM w1", 3'd3, C_MLD);
    cyc("lw MEM w2", 3'd3, C_MLD);
    mem_ready = 1'b1;
    cyc("lw MEM rdy", 3'd3, C_MLD);
    mem_ready = 1'b0;
    cyc("lw WB", 3'd4, mk(0, 0, 0, 0, 1, 3'b000, 1, 2'b01, 1, 0));
    chk("lw cnt", instr_cnt, 32'd2);

    // beq taken then not taken
    Op = 7'b1100011; Zero = 1'b1; mem_ready = 1'b1;
    cyc("beq1 IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("beq1 ID", 3'd1, C0);
    cyc("beq1 EX", 3'd2, mk(0, 0, 0, 0, 1, 3'b001, 0, 2'b00, 1, 0));
    Zero = 1'b0; mem_ready = 1'b1;
    cyc("beq0 IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("beq0 ID", 3'd1, C0);
    cyc("beq0 EX", 3'd2, mk(0, 0, 0, 0, 1, 3'b000, 0, 2'b00, 1, 0));
    chk("beq cnt", instr_cnt, 32'd4);

    // jalr then jal
    Op = 7'b1100111; mem_ready = 1'b1;
    cyc("jalr IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("jalr ID", 3'd1, C0);
    cyc("jalr EX", 3'd2, C0);
    cyc("jalr WB", 3'd4, mk(0, 0, 0, 0, 1, 3'b100, 1, 2'b10, 1, 0));
    Op = 7'b1101111; mem_ready = 1'b1;
    cyc("jal IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("jal ID", 3'd1, C0);
    cyc("jal EX", 3'd2, C0);
    cyc("jal WB", 3'd4, mk(0, 0, 0, 0, 1, 3'b010, 1, 2'b10, 1, 0));
    chk("jump cnt", instr_cnt, 32'd6);

    // sw, zero-wait
    Op = 7'b0100011; mem_ready = 1'b1;
    cyc("sw IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("sw ID", 3'd1, C0);
    cyc("sw EX", 3'd2, C0);
    mem_ready = 1'b1;
    cyc("sw MEM", 3'd3, C_MSTD);
    chk("sw cnt", instr_cnt, 32'd7);

    // lw with ready arriving exactly at the wait limit: completes
    Op = 7'b0000011;
    cyc("lwlim IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("lwlim ID", 3'd1, C0);
    cyc("lwlim EX", 3'd2, C0);
    for (int i = 0; i < int'(MT); i++) cyc("lwlim MEM wait", 3'd3, C_MLD);
    mem_ready = 1'b1;
    cyc("lwlim MEM rdy", 3'd3, C_MLD);
    mem_ready = 1'b0;
    cyc("lwlim WB", 3'd4, mk(0, 0, 0, 0, 1, 3'b000, 1, 2'b01, 1, 0));
    chk("lwlim cnt", instr_cnt, 32'd8);

    // fetch timeout: MT+1 unanswered request cycles, then TRAP
    for (int i = 0; i <= int'(MT); i++) cyc("fetch wait", 3'd0, C_IFW);
    cyc("fetch trap", 3'd7, C_TRAP);
    mem_ready = 1'b1;
    cyc("trap ignores rdy", 3'd7, C_TRAP);
    chk("trap cnt held", instr_cnt, 32'd8);
    rst = 1'b1;
    cyc("trap rst", 3'd0, C0);
    rst = 1'b0; mem_ready = 1'b0; Op = 7'b1111111;
    chk("cnt cleared", instr_cnt, 32'd0);

    // illegal opcode
    cyc("ill IF wait", 3'd0, C_IFW);
    mem_ready = 1'b1;
    cyc("ill IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("ill ID", 3'd1, C0);
    cyc("ill trap", 3'd7, C_TRAP);
    rst = 1'b1;
    cyc("ill rst", 3'd0, C0);
    rst = 1'b0;

    // data timeout in MEM
    Op = 7'b0000011; mem_ready = 1'b1;
    cyc("lwto IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("lwto ID", 3'd1, C0);
    cyc("lwto EX", 3'd2, C0);
    for (int i = 0; i <= int'(MT); i++) cyc("lwto MEM wait", 3'd3, C_MLD);
    cyc("lwto trap", 3'd7, C_TRAP);
    rst = 1'b1;
    cyc("lwto rst", 3'd0, C0);
    rst = 1'b0;

    // sw aborted by reset mid-MEM
    Op = 7'b0100011; mem_ready = 1'b1;
    cyc("swab IF", 3'd0, C_IFR);
    mem_ready = 1'b0;
    cyc("swab ID", 3'd1, C0);
    cyc("swab EX", 3'd2, C0);
    cyc("swab MEM", 3'd3, C_MSTW);
    rst = 1'b1; mem_ready = 1'b1;
    cyc("swab rst", 3'd0, C0);
    rst = 1'b0; mem_ready = 1'b0;
    chk("swab cnt", instr_cnt, 32'd0);
    cyc("swab IF after", 3'd0, C_IFW);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath: steps each instruction through IF/ID/EX/MEM/WB over a shared, variable-latency instruction/data memory port.
- Generates per-state enables: PC, IR, regfile, memory request, address mux, write-data select, next-PC op.
- Per-instruction ALUOp/EXTOp decode stays in the existing combinational decoder; this block owns only sequencing, the memory handshake, timeout and retired-instruction count.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request waits for mem_ready before bus error; range 1..255.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  7  opcode from IR.
- Funct3  in  3  funct3 from IR.
- Zero  in  1  ALU branch-condition flag (1 = taken).
- mem_ready  in  1  memory completes current request this cycle.
- MemReq  out  1  memory request valid.
- MemWrite  out  1  request is a write; only with MemReq.
- AddrSel  out  1  0 = PC, 1 = ALU result.
- IRWrite  out  1  latch fetched word into IR.
- PCWrite  out  1  update PC with NPCOp result.
- NPCOp  out  3  000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR.
- RegWrite  out  1  register-file write enable.
- WDSel  out  2  00 ALU, 01 MEM, 10 PC+4.
- state  out  3  current state encoding.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_cnt  out  CNT_W  retired-instruction count.
- trap  out  1  sticky: illegal opcode or bus timeout.

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7. One state register; outputs are combinational from state, Op and mem_ready.
- Reset: while rst=1, next state is IF, and instr_cnt, timeout counter and trap clear. All outputs are forced 0, including MemReq.
- First cycle after rst drops: state=IF, MemReq=1.
- IF: MemReq=1, AddrSel=0.
  - mem_ready=1: IRWrite=1 in the same cycle, go to ID.
  - Otherwise stay in IF.
- ID: no enables asserted.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. A legal opcode goes to EX.
  - Any other opcode goes to TRAP.
- EX:
  - Branch (1100011): PCWrite=1, NPCOp=001 if Zero else 000, instr_done=1, go to IF. Funct3 is not examined here.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM: MemReq=1, AddrSel=1, MemWrite=1 for store only.
  - Waits for mem_ready.
  - Load completing: go to WB.
  - Store completing: PCWrite=1, NPCOp=000, instr_done=1, go to IF.
- WB: RegWrite=1, PCWrite=1, instr_done=1, go to IF.
  - WDSel: 01 for load, 10 for jal/jalr, else 00.
  - NPCOp: 010 for jal, 100 for jalr, else 000.
- Timeout:
  - 8-bit wait counter clears on entry to IF or MEM and increments each cycle MemReq=1 && mem_ready=0.
  - Reaching MEM_TIMEOUT with mem_ready still 0 goes to TRAP next cycle; no IRWrite.
  - mem_ready in the same cycle the counter hits the limit completes normally (ready wins).
  - Total wait: mem_ready at wait cycle k ≤ MEM_TIMEOUT completes; otherwise TRAP is entered after MEM_TIMEOUT+1 request cycles.
- TRAP: all enables 0, trap=1, held until rst. mem_ready is ignored.
- instr_cnt:
  - Increments by 1 on every instr_done cycle and wraps at 2^CNT_W−1 → 0.
  - instr_done is never asserted in TRAP.
- Reset mid-operation: any state returns to IF and an outstanding request is abandoned. mem_ready arriving during or after reset for the old request is not distinguished; memory must drop it on rst.
- mem_ready outside IF/MEM is ignored.
- Per-class latency with zero-wait memory (mem_ready=1 same cycle):
  - Branch 3 cycles.
  - ALU/jal/jalr/lui/auipc 4 cycles.
  - Store 4 cycles.
  - Load 5 cycles.

Test Plan:
- add (Op 0110011), mem_ready held 1 → states IF,ID,EX,WB; RegWrite=1, WDSel=00 only in WB; instr_done at cycle 4; instr_cnt=1.
- lw (0000011), fetch ready immediately, data ready after 3 wait cycles → MEM held 4 cycles with MemReq=1, AddrSel=1, MemWrite=0; WB with WDSel=01; total 8 cycles.
- beq with Zero=1 then Zero=0 → EX with PCWrite=1 and NPCOp=001, then 000; no RegWrite; each retires in 3 cycles; instr_cnt=2.
- jalr (1100111) → WB: WDSel=10, NPCOp=100, RegWrite=1. jal → NPCOp=010.
- Fetch with mem_ready=0 for MEM_TIMEOUT+1 cycles → TRAP, trap=1, all enables 0. mem_ready=1 later has no effect. rst for 1 cycle → IF, trap=0, instr_cnt=0.
- Opcode 1111111 → ID then TRAP. sw with rst asserted mid-MEM → next cycle IF with MemReq=0 during reset, no PCWrite or instr_done for the aborted store.
